// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_WB,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // 3-bit ALUs use only the low bits of these codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder_ext.sv
// ALU control decoder: maps the FSM's ALU class plus funct fields to an
// ALU operation, flagging encodings the configured ALU cannot execute.
module alu_decoder_ext
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  aluop_t              i_alu_op,
  input  logic [2:0]          i_funct3,
  input  logic                i_funct7b5,
  input  logic                i_op5,
  output logic [ALUCTL_W-1:0] o_alu_control,
  output logic                o_unsupported
);

  logic [ALUCTL_W-1:0] w_code;

  always_comb begin
    w_code        = ALU_ADD[ALUCTL_W-1:0];
    o_unsupported = 1'b0;
    case (i_funct3)
      3'b000:  w_code = (i_op5 && i_funct7b5) ? ALU_SUB[ALUCTL_W-1:0] : ALU_ADD[ALUCTL_W-1:0];
      3'b001:  w_code = ALU_SLL[ALUCTL_W-1:0];
      3'b010:  w_code = ALU_SLT[ALUCTL_W-1:0];
      3'b011:  w_code = ALU_SLTU[ALUCTL_W-1:0];
      3'b100:  w_code = ALU_XOR[ALUCTL_W-1:0];
      3'b101:  w_code = i_funct7b5 ? ALU_SRA[ALUCTL_W-1:0] : ALU_SRL[ALUCTL_W-1:0];
      3'b110:  w_code = ALU_OR[ALUCTL_W-1:0];
      default: w_code = ALU_AND[ALUCTL_W-1:0];
    endcase
    if (ALUCTL_W < 4 && (i_funct3 inside {3'b001, 3'b011, 3'b100, 3'b101}))
      o_unsupported = 1'b1;
    // op5 marks R-type, where funct7b5 is a real opcode bit rather than immediate
    if (i_op5 && i_funct7b5 && i_funct3 != 3'b000 && !(ALUCTL_W >= 4 && i_funct3 == 3'b101))
      o_unsupported = 1'b1;

    case (i_alu_op)
      ALUOP_SUB:   o_alu_control = ALU_SUB[ALUCTL_W-1:0];
      ALUOP_FUNCT: o_alu_control = w_code;
      default:     o_alu_control = ALU_ADD[ALUCTL_W-1:0];
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I controller: sequences fetch/decode/execute over a
// shared-ALU single-memory datapath, stalling on mem_ready.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W      = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_write,
  output logic                mem_read,
  output logic                adr_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                retire,
  output logic                illegal_op
);

  state_t r_state, w_state_next, w_decode_next;
  aluop_t w_alu_op;
  logic   w_unsupported, w_ready, w_taken;
  logic   w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_mem_read, w_retire;

  alu_decoder_ext #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (alu_control),
    .o_unsupported (w_unsupported)
  );

  assign w_ready    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign imm_src    = imm_src_of(op);
  assign illegal_op = (r_state == S_TRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_decode_next = S_TRAP;
    case (op)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) w_decode_next = S_MEMADR;
      OP_RTYPE:  if (!w_unsupported) w_decode_next = S_EXECR;
      OP_ITYPE:  if (!w_unsupported) w_decode_next = S_EXECI;
      OP_BRANCH: if (funct3[2:1] != 2'b01) w_decode_next = S_BRANCH;
      OP_JAL:    w_decode_next = S_JAL;
      OP_JALR:   w_decode_next = S_JALR;
      OP_LUI:    w_decode_next = S_LUI;
      OP_AUIPC:  w_decode_next = S_AUIPC;
      default:   w_decode_next = S_TRAP;
    endcase

    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_retire     = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_B;
    result_src   = RES_ALUOUT;
    w_alu_op     = ALUOP_ADD;
    unique case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (w_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        w_state_next = w_decode_next;
      end
      S_MEMADR: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_IMM;
        w_state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        w_mem_read = 1'b1;
        if (w_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_DATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (w_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a    = SRCA_A;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_A;
        w_alu_op     = ALUOP_SUB;
        w_pc_write   = w_taken;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_IMM;
        result_src   = RES_ALU;
        w_pc_write   = 1'b1;
        w_state_next = S_JALR_WB;
      end
      S_JALR_WB: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_LUI: begin
        alu_src_a    = SRCA_ZERO;
        alu_src_b    = SRCB_IMM;
        w_state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        w_state_next = S_ALUWB;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
    endcase
  end

  // Enables are masked while reset is high so an aborted access never writes
  assign pc_write  = w_pc_write  & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign mem_read  = w_mem_read  & ~reset;
  assign retire    = w_retire    & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: a 4-bit-ALU instance checked against a vector table and
// multi-cycle sequences, plus a 3-bit-ALU instance for the trap cases.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic       funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;

  logic       pcw4, irw4, rw4, mw4, mr4, adr4, ret4, ill4;
  logic [1:0] sa4, sb4, rs4;
  logic [2:0] imm4;
  logic [3:0] alu4;
  logic       pcw3, irw3, rw3, mw3, mr3, adr3, ret3, ill3;
  logic [1:0] sa3, sb3, rs3;
  logic [2:0] imm3;
  logic [2:0] alu3;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUCTL_W(4), .MEM_HANDSHAKE(1'b1)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_write(pcw4), .ir_write(irw4), .reg_write(rw4), .mem_write(mw4), .mem_read(mr4),
    .adr_src(adr4), .alu_src_a(sa4), .alu_src_b(sb4), .result_src(rs4), .imm_src(imm4),
    .alu_control(alu4), .retire(ret4), .illegal_op(ill4));

  multicycle_control_unit #(.ALUCTL_W(3), .MEM_HANDSHAKE(1'b1)) dut3 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .pc_write(pcw3), .ir_write(irw3), .reg_write(rw3), .mem_write(mw3), .mem_read(mr3),
    .adr_src(adr3), .alu_src_a(sa3), .alu_src_b(sb3), .result_src(rs3), .imm_src(imm3),
    .alu_control(alu3), .retire(ret3), .illegal_op(ill3));

  typedef struct packed {
    logic pcw, irw, rw, mw, mr, adr;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic ret;
  } snap_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z; logic l; logic lu;
    int cyc; logic [3:0] alu; logic pc3; int rw; logic [2:0] imm; logic ill;
  } vec_t;

  snap_t      snap [0:15];
  logic [2:0] alu3_hist [0:15];
  vec_t       vecs [$];
  int         checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Resets, presents one instruction and records up to 12 cycles of dut4 outputs
  task automatic run_instr(input logic [6:0] i_op, input logic [2:0] i_f3, input logic i_f7,
                           input logic i_z, input logic i_l, input logic i_lu,
                           input int stall_lo, input int stall_hi, output int cyc);
    reset = 1'b1; op = i_op; funct3 = i_f3; funct7b5 = i_f7;
    zero = i_z; lt = i_l; ltu = i_lu; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin snap[k] = '0; alu3_hist[k] = '0; end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      mem_ready = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
      #1;
      snap[c] = {pcw4, irw4, rw4, mw4, mr4, adr4, sa4, sb4, rs4, imm4, alu4, ret4};
      alu3_hist[c] = alu3;
      if (ret4) begin cyc = c; break; end
      @(negedge clk);
    end
  endtask

  function automatic int count_rw();
    int n = 0;
    for (int c = 1; c <= 12; c++) n += int'(snap[c].rw);
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    logic [5:0] en;

    //               op          f3    f7 z  l  lu cyc alu    pc3 rw imm    ill
    vecs.push_back('{7'b0000011, 3'b010, 0, 0, 0, 0, 5, 4'h0, 0, 1, 3'b000, 0}); // lw
    vecs.push_back('{7'b0100011, 3'b010, 0, 0, 0, 0, 4, 4'h0, 0, 0, 3'b001, 0}); // sw
    vecs.push_back('{7'b0110011, 3'b000, 0, 0, 0, 0, 4, 4'h0, 0, 1, 3'b000, 0}); // add
    vecs.push_back('{7'b0110011, 3'b000, 1, 0, 0, 0, 4, 4'h1, 0, 1, 3'b000, 0}); // sub
    vecs.push_back('{7'b0110011, 3'b100, 0, 0, 0, 0, 4, 4'h4, 0, 1, 3'b000, 0}); // xor
    vecs.push_back('{7'b0110011, 3'b101, 1, 0, 0, 0, 4, 4'h9, 0, 1, 3'b000, 0}); // sra
    vecs.push_back('{7'b0110011, 3'b011, 0, 0, 0, 0, 4, 4'h6, 0, 1, 3'b000, 0}); // sltu
    vecs.push_back('{7'b0110011, 3'b110, 0, 0, 0, 0, 4, 4'h3, 0, 1, 3'b000, 0}); // or
    vecs.push_back('{7'b0010011, 3'b000, 1, 0, 0, 0, 4, 4'h0, 0, 1, 3'b000, 0}); // addi, imm bit30 set
    vecs.push_back('{7'b0010011, 3'b101, 1, 0, 0, 0, 4, 4'h9, 0, 1, 3'b000, 0}); // srai
    vecs.push_back('{7'b0010011, 3'b111, 0, 0, 0, 0, 4, 4'h2, 0, 1, 3'b000, 0}); // andi
    vecs.push_back('{7'b0010011, 3'b010, 0, 0, 0, 0, 4, 4'h5, 0, 1, 3'b000, 0}); // slti
    vecs.push_back('{7'b1100011, 3'b000, 0, 1, 0, 0, 3, 4'h1, 1, 0, 3'b010, 0}); // beq taken
    vecs.push_back('{7'b1100011, 3'b001, 0, 1, 0, 0, 3, 4'h1, 0, 0, 3'b010, 0}); // bne not taken
    vecs.push_back('{7'b1100011, 3'b001, 0, 0, 0, 0, 3, 4'h1, 1, 0, 3'b010, 0}); // bne taken
    vecs.push_back('{7'b1100011, 3'b100, 0, 0, 1, 0, 3, 4'h1, 1, 0, 3'b010, 0}); // blt taken
    vecs.push_back('{7'b1100011, 3'b101, 0, 0, 1, 0, 3, 4'h1, 0, 0, 3'b010, 0}); // bge not taken
    vecs.push_back('{7'b1100011, 3'b111, 0, 0, 0, 0, 3, 4'h1, 1, 0, 3'b010, 0}); // bgeu taken
    vecs.push_back('{7'b1100011, 3'b110, 0, 0, 0, 0, 3, 4'h1, 0, 0, 3'b010, 0}); // bltu not taken
    vecs.push_back('{7'b1101111, 3'b000, 0, 0, 0, 0, 4, 4'h0, 1, 1, 3'b011, 0}); // jal
    vecs.push_back('{7'b1100111, 3'b000, 0, 0, 0, 0, 4, 4'h0, 1, 1, 3'b000, 0}); // jalr
    vecs.push_back('{7'b0110111, 3'b000, 0, 0, 0, 0, 4, 4'h0, 0, 1, 3'b100, 0}); // lui
    vecs.push_back('{7'b0010111, 3'b000, 0, 0, 0, 0, 4, 4'h0, 0, 1, 3'b100, 0}); // auipc
    vecs.push_back('{7'b1111111, 3'b000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'b000, 1}); // unknown op
    vecs.push_back('{7'b1100011, 3'b010, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'b010, 1}); // bad branch f3
    vecs.push_back('{7'b0000011, 3'b000, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'b000, 1}); // lb unsupported
    vecs.push_back('{7'b0100011, 3'b011, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3'b001, 1}); // bad store f3
    vecs.push_back('{7'b0110011, 3'b001, 1, 0, 0, 0, 0, 4'h0, 0, 0, 3'b000, 1}); // R f7b5 with sll

    // Reset state: enables masked, no trap
    @(negedge clk); #1;
    chk("reset_enables", {pcw4, irw4, rw4, mw4, mr4, ret4}, 6'b0);
    chk("reset_illegal", {ill4, ill3}, 2'b00);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].l, vecs[i].lu, 0, 0, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_alu_c3", i), snap[3].alu, vecs[i].alu);
      chk($sformatf("v%0d_pcw_c3", i), snap[3].pcw, vecs[i].pc3);
      chk($sformatf("v%0d_regwrites", i), count_rw(), vecs[i].rw);
      chk($sformatf("v%0d_imm_src", i), snap[1].imm, vecs[i].imm);
      chk($sformatf("v%0d_illegal", i), ill4, vecs[i].ill);
      chk($sformatf("v%0d_fetch", i),
          {snap[1].pcw, snap[1].irw, snap[1].mr, snap[1].adr, snap[1].sa, snap[1].sb, snap[1].rs},
          10'b1_1_1_0_00_10_10);
    end

    // lw: state walk and single write-back in cycle 5
    run_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 0, cyc);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("lw_c%0d_rw_ret", c), {snap[c].rw, snap[c].ret}, (c == 5) ? 2'b11 : 2'b00);
    end
    chk("lw_decode_srcs", {snap[2].sa, snap[2].sb}, 4'b0101);
    chk("lw_memadr_srcs", {snap[3].sa, snap[3].sb}, 4'b1001);
    chk("lw_memread", {snap[4].adr, snap[4].mr}, 2'b11);
    chk("lw_memwb_res", snap[5].rs, 2'b01);

    // sw with mem_ready low for three MEMWRITE cycles
    run_instr(7'b0100011, 3'b010, 0, 0, 0, 0, 4, 6, cyc);
    chk("sw_stall_cycles", cyc, 7);
    n = 0; for (int c = 1; c <= 12; c++) n += int'(snap[c].mw);
    chk("sw_stall_mw_cycles", n, 4);
    n = 0; for (int c = 1; c <= 12; c++) n += int'(snap[c].ret);
    chk("sw_stall_retires", n, 1);
    chk("sw_stall_adr_held", {snap[4].adr, snap[5].adr, snap[6].adr, snap[7].adr}, 4'b1111);

    // lw with two stalled FETCH cycles
    run_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 1, 2, cyc);
    chk("fetch_stall_cycles", cyc, 7);
    n = 0; for (int c = 1; c <= 12; c++) n += int'(snap[c].irw);
    chk("fetch_stall_irw_count", n, 1);
    chk("fetch_stall_irw_c3", {snap[1].mr, snap[2].mr, snap[3].irw}, 3'b111);

    // jalr detail
    run_instr(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 0, cyc);
    chk("jalr_c3", {snap[3].pcw, snap[3].rs}, 3'b1_10);
    chk("jalr_wb_c4", {snap[4].rw, snap[4].sa, snap[4].sb, snap[4].rs}, 7'b1_01_10_10);

    // 3-bit ALU: legal codes use the low bits
    run_instr(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 0, cyc);
    chk("w3_sub_alu", alu3_hist[3], 3'b001);
    run_instr(7'b0110011, 3'b010, 0, 0, 0, 0, 0, 0, cyc);
    chk("w3_slt_alu", alu3_hist[3], 3'b101);

    // xor: traps on the 3-bit ALU, executes on the 4-bit ALU
    run_instr(7'b0110011, 3'b100, 0, 0, 0, 0, 0, 0, cyc);
    chk("w4_xor_alu", snap[3].alu, 4'b0100);
    chk("w4_xor_cycles", cyc, 4);
    chk("w3_xor_illegal", ill3, 1'b1);
    op = 7'b0110011; funct3 = 3'b000;
    en = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      en |= {pcw3, irw3, rw3, mw3, mr3, ret3};
    end
    chk("w3_trap_no_enables", en, 6'b0);
    chk("w3_illegal_sticky", ill3, 1'b1);
    reset = 1'b1; #1;
    chk("w3_illegal_cleared", ill3, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Reset asserted in MEMREAD aborts the load
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0; #1;
    chk("rst_in_memread_pre", {mr4, adr4}, 2'b11);
    #2 reset = 1'b1; #1;
    chk("rst_in_memread_async", {mr4, adr4, rw4}, 3'b000);
    @(posedge clk); #1;
    chk("rst_in_memread_hold", {mr4, rw4, pcw4, irw4}, 4'b0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("rst_in_memread_fetch", {mr4, adr4, rw4, sb4}, 5'b1_0_0_10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle RISC-V RV32I controller FSM. It is the parametrised successor of the single-cycle controller and drives a shared-ALU, single-memory datapath with PC, OldPC, IR, A/B, ALUOut and Data registers. It sequences every instruction through fetch/decode/execute states and stalls on a memory-ready handshake. It adds bne/blt/bge/bltu/bgeu, jalr, lui and auipc, an optional 4-bit extended ALU control, and an illegal-instruction trap.

## Interface
- ALUCTL_W, 3: ALU control width. 3 gives add/sub/and/or/slt. 4 adds xor/sltu/sll/srl/sra.
- MEM_HANDSHAKE, 1: 1 means memory states wait for mem_ready. 0 means mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero, lt, ltu  in  1 each  ALU flags: result==0, signed rs1<rs2, unsigned rs1<rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, ir_write, reg_write, mem_write, mem_read  out  1 each  enables.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 A, 11 constant 0.
- alu_src_b  out  2  00 B, 01 imm, 10 constant 4.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALU result.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_control  out  ALUCTL_W  ALU operation.
- retire  out  1  1-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  sticky trap flag.

## Operation
- imm_src is decoded combinationally from op in every state.
- All other outputs are decoded from the state, plus the qualifiers noted below.
- Unlisted signals are 0. "add" means alu_control = ALU_ADD.

States and per-state behaviour:
- FETCH: adr_src=0, mem_read=1, a=00, b=10, add, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE; otherwise hold.
- DECODE: a=01, b=01, add (branch/jal target into ALUOut).
  - lw/sw go to MEMADR. R-type goes to EXECR. I-ALU goes to EXECI.
  - Branch goes to BRANCH, jal to JAL, jalr to JALR.
  - lui goes to LUI, auipc to AUIPC.
  - Any illegal encoding goes to TRAP.
- MEMADR: a=10, b=01, add. lw goes to MEMREAD; sw goes to MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire. Go to FETCH.
- MEMWRITE: adr_src=1, mem_write=1. On mem_ready: retire, go to FETCH.
- EXECR: a=10, b=00, alu_control from funct3/funct7b5. Go to ALUWB.
- EXECI: a=10, b=01, alu_control from funct3 (funct7b5 only for shifts). Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire. Go to FETCH.
- BRANCH: a=10, b=00, sub, result_src=00, retire. Go to FETCH.
  - pc_write = taken. Taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- JAL: a=01, b=10, add, result_src=00, pc_write=1. Go to ALUWB.
- JALR: a=10, b=01, add, result_src=10, pc_write=1. Go to JALR_WB.
- JALR_WB: a=01, b=10, add, result_src=10, reg_write=1, retire. Go to FETCH.
- LUI: a=11, b=01, add. Go to ALUWB.
- AUIPC: a=01, b=01, add. Go to ALUWB.
- TRAP: all enables 0, illegal_op=1. Only reset exits this state.

Illegal encodings, checked in DECODE:
- Unknown opcode.
- Branch funct3 of 010 or 011.
- lw/sw with funct3 ≠ 010.
- When ALUCTL_W=3: any op needing xor/sltu/sll/srl/sra, i.e. funct3 of 001, 011, 100 or 101.
- R-type funct7b5=1 with funct3 other than 000 (or 101 when ALUCTL_W=4).

## Timing
- Reset value: state=FETCH and illegal_op=0.
- While reset is high, pc_write, ir_write, reg_write, mem_write, mem_read and retire are forced to 0.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after the reset edge.
- Cycles per instruction with mem_ready=1:
  - lw: 5.
  - sw, R-type, I-ALU, jal, jalr, lui, auipc: 4.
  - Branch: 3.
- Each low mem_ready cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Outputs are held stable throughout a wait.
- Branch flags are sampled combinationally in the same BRANCH cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - ALU_* codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101, XOR 0100, SLTU 0110, SLL 0111, SRL 1000, SRA 1001 (3-bit codes are the low bits);
  - imm_src and mux-select constants.
- Sub-module alu_decoder_ext (parameter ALUCTL_W) maps alu_op class, funct3, funct7b5 and op[5] to alu_control and an unsupported flag.

## Test plan
- Reset with an lw in IR and mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 and retire only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write=1 held for 4 cycles, retire once; total 7 cycles.
- bne (funct3=001): zero=0 gives pc_write=1 in BRANCH; zero=1 gives pc_write=0. Both take 3 cycles.
- jalr → pc_write=1 with result_src=10 in JALR; reg_write=1 with a=01, b=10 in JALR_WB.
- ALUCTL_W=3 with R-type xor (funct3=100) → TRAP, illegal_op=1 sticky, no enables. Reset clears illegal_op; ALUCTL_W=4 gives alu_control=0100.
- Reset asserted in MEMREAD → state returns to FETCH asynchronously, mem_read=0 while reset high, no reg_write.
